// File: rtl/trigger_capture.sv
// Oscilloscope trigger/capture into ping-pong frame banks; screenData is registered (1-cycle read latency).
// sample_en strobes are always accepted (no backpressure). Define TRIG_CAPTURE_AUTO_EN for the auto-trigger timeout.
module trigger_capture #(
  parameter int DATA_W       = 12,
  parameter int DEPTH        = 640,
  parameter int PRETRIG      = 64,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] adc_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic              run,
  input  logic              arm,
  input  logic [10:0]       screenX,
  output logic [DATA_W-1:0] screenData,
  output logic              busy,
  output logic              triggered,
  output logic              frame_ready
);
  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW-1:0] PRE_LAST  = AW'(PRETRIG - 1);
  localparam logic [AW-1:0] POST_LAST = AW'(DEPTH - PRETRIG - 2);
  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_X   = (AW+1)'(DEPTH);

  // screenX is 11 bits wide, so frames longer than 2048 columns cannot be addressed.
  if (PRETRIG < 1 || PRETRIG > DEPTH - 2 || DEPTH > 2048 || AUTO_TIMEOUT < 1) begin : g_bad_cfg
    $error("trigger_capture: unsupported DEPTH/PRETRIG/AUTO_TIMEOUT");
  end

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_HOLD} state_t;

  logic [DATA_W-1:0] r_bank0 [DEPTH];
  logic [DATA_W-1:0] r_bank1 [DEPTH];
  state_t            r_state;
  logic [AW-1:0]     r_wr_addr, r_cnt, r_start_addr, r_rd_start;
  logic              r_wr_bank, r_frame_valid;
  logic [DATA_W-1:0] r_level, r_prev, r_screen_data;
  logic              r_slope, r_busy, r_triggered, r_frame_ready;

  logic              w_wr_en, w_hit, w_trig, w_start_cap, w_col_oob;
  logic [AW-1:0]     w_next_addr, w_trig_start, w_rd_idx;
  logic [AW:0]       w_rd_sum;

  assign w_wr_en      = sample_en && (r_state == S_PRE || r_state == S_WAIT || r_state == S_POST);
  assign w_next_addr  = (r_wr_addr == ADDR_LAST) ? '0 : r_wr_addr + 1'b1;
  assign w_trig_start = (r_wr_addr >= AW'(PRETRIG)) ? r_wr_addr - AW'(PRETRIG)
                                                    : r_wr_addr + AW'(DEPTH - PRETRIG);
  assign w_hit        = r_slope ? (r_prev > r_level && adc_data <= r_level)
                                : (r_prev < r_level && adc_data >= r_level);
  assign w_start_cap  = run | arm;

`ifdef TRIG_CAPTURE_AUTO_EN
  localparam int TW = $clog2(AUTO_TIMEOUT + 1);
  logic [TW-1:0] r_to_cnt;
  assign w_trig = w_hit || (r_to_cnt == TW'(AUTO_TIMEOUT - 1));
`else
  assign w_trig = w_hit;
`endif

  // Column maps onto the ring starting at the published frame's oldest sample.
  assign w_col_oob = ({1'b0, screenX} >= 12'(DEPTH));
  assign w_rd_sum  = {1'b0, screenX[AW-1:0]} + {1'b0, r_rd_start};
  assign w_rd_idx  = (w_rd_sum >= DEPTH_X) ? AW'(w_rd_sum - DEPTH_X) : w_rd_sum[AW-1:0];

  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      if (r_wr_bank) r_bank1[r_wr_addr] <= adc_data;
      else           r_bank0[r_wr_addr] <= adc_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset || !r_frame_valid || w_col_oob) r_screen_data <= '0;
    else if (r_wr_bank)                        r_screen_data <= r_bank0[w_rd_idx];
    else                                       r_screen_data <= r_bank1[w_rd_idx];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_wr_addr     <= '0;
      r_cnt         <= '0;
      r_start_addr  <= '0;
      r_rd_start    <= '0;
      r_wr_bank     <= 1'b0;
      r_frame_valid <= 1'b0;
      r_level       <= '0;
      r_slope       <= 1'b0;
      r_prev        <= '0;
      r_busy        <= 1'b0;
      r_triggered   <= 1'b0;
      r_frame_ready <= 1'b0;
`ifdef TRIG_CAPTURE_AUTO_EN
      r_to_cnt      <= '0;
`endif
    end else begin
      r_frame_ready <= 1'b0;
      if (w_wr_en) begin
        r_wr_addr <= w_next_addr;
        r_prev    <= adc_data;
      end
      case (r_state)
        S_IDLE, S_HOLD: if (w_start_cap) begin
          r_state <= S_PRE;
          r_busy  <= 1'b1;
          r_cnt   <= '0;
          r_level <= trig_level;
          r_slope <= trig_slope;
`ifdef TRIG_CAPTURE_AUTO_EN
          r_to_cnt <= '0;
`endif
        end
        S_PRE: if (sample_en) begin
          if (r_cnt == PRE_LAST) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT: if (sample_en) begin
          if (w_trig) begin
            r_state      <= S_POST;
            r_triggered  <= 1'b1;
            r_start_addr <= w_trig_start;
            r_cnt        <= '0;
          end
`ifdef TRIG_CAPTURE_AUTO_EN
          else r_to_cnt <= r_to_cnt + 1'b1;
`endif
        end
        S_POST: if (sample_en) begin
          if (r_cnt == POST_LAST) begin
            // The last post-trigger sample lands in the old bank on this same edge.
            r_wr_bank     <= ~r_wr_bank;
            r_rd_start    <= r_start_addr;
            r_frame_valid <= 1'b1;
            r_frame_ready <= 1'b1;
            r_triggered   <= 1'b0;
            r_cnt         <= '0;
            if (run) begin
              r_state <= S_PRE;
              r_level <= trig_level;
              r_slope <= trig_slope;
`ifdef TRIG_CAPTURE_AUTO_EN
              r_to_cnt <= '0;
`endif
            end else begin
              r_state <= S_HOLD;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_triggered <= 1'b0;
        end
      endcase
    end
  end

  assign screenData  = r_screen_data;
  assign busy        = r_busy;
  assign triggered   = r_triggered;
  assign frame_ready = r_frame_ready;
endmodule

// File: tb/tb_trigger_capture.sv
// Directed bench for trigger_capture: a capture-list model (frame = last DEPTH samples of a capture)
// is checked every cycle, plus literal expectations for known ramps.
module tb_trigger_capture;
  localparam int DATA_W       = 12;
  localparam int DEPTH        = 640;
  localparam int PRETRIG      = 64;
  localparam int AUTO_TIMEOUT = 4096;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              sample_en = 1'b0;
  logic [DATA_W-1:0] adc_data = '0;
  logic [DATA_W-1:0] trig_level = '0;
  logic              trig_slope = 1'b0;
  logic              run = 1'b0;
  logic              arm = 1'b0;
  logic [10:0]       screenX = '0;
  logic [DATA_W-1:0] screenData;
  logic              busy, triggered, frame_ready;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // model state
  bit m_active, m_trig, m_valid, m_slope;
  int m_n, m_wait, m_post_left, m_lvl;
  int m_frame[DEPTH];
  int m_cap[$];
  int e_busy, e_trig, e_ready, e_data;

  trigger_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PRETRIG(PRETRIG), .AUTO_TIMEOUT(AUTO_TIMEOUT)) dut (
    .clock(clock), .reset(reset), .sample_en(sample_en), .adc_data(adc_data),
    .trig_level(trig_level), .trig_slope(trig_slope), .run(run), .arm(arm),
    .screenX(screenX), .screenData(screenData), .busy(busy), .triggered(triggered),
    .frame_ready(frame_ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic start_capture();
    m_active = 1'b1;
    m_trig   = 1'b0;
    m_n      = 0;
    m_wait   = 0;
    m_lvl    = int'(trig_level);
    m_slope  = trig_slope;
    m_cap.delete();
  endtask

  // Advances the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit hit;
    int cur, prev;
    if (!reset) begin
      m_active = 1'b0;
      m_trig   = 1'b0;
      m_valid  = 1'b0;
      e_data   = 0;
      e_ready  = 0;
      m_cap.delete();
    end else begin
      e_data  = (m_valid && screenX < DEPTH) ? m_frame[screenX] : 0;
      e_ready = 0;
      if (!m_active) begin
        if (run || arm) start_capture();
      end else if (sample_en) begin
        cur = int'(adc_data);
        if (m_n >= PRETRIG && !m_trig) begin
          prev = m_cap[m_cap.size() - 1];
          m_wait++;
          hit = m_slope ? (prev > m_lvl && cur <= m_lvl) : (prev < m_lvl && cur >= m_lvl);
`ifdef TRIG_CAPTURE_AUTO_EN
          if (m_wait == AUTO_TIMEOUT) hit = 1'b1;
`endif
          if (hit) begin
            m_trig      = 1'b1;
            m_post_left = DEPTH - PRETRIG - 1;
          end
        end else if (m_trig) begin
          m_post_left--;
        end
        m_cap.push_back(cur);
        if (m_cap.size() > DEPTH) void'(m_cap.pop_front());
        m_n++;
        if (m_trig && m_post_left == 0) begin
          for (int x = 0; x < DEPTH; x++) m_frame[x] = m_cap[x];
          m_valid = 1'b1;
          e_ready = 1;
          if (run) start_capture();
          else m_active = 1'b0;
        end
      end
    end
    e_busy = m_active ? 1 : 0;
    e_trig = (m_active && m_trig) ? 1 : 0;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic strobe(input logic [DATA_W-1:0] v);
    adc_data  = v;
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
  endtask

  task automatic peek(input int x, input int exp, input string name);
    screenX = 11'(x);
    tick();
    check(name, 32'(screenData), exp);
  endtask

  task automatic reset_dut();
    run = 1'b0; arm = 1'b0; sample_en = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("cyc_busy", 32'(busy), e_busy);
      check("cyc_triggered", 32'(triggered), e_trig);
      check("cyc_frame_ready", 32'(frame_ready), e_ready);
      check("cyc_screenData", 32'(screenData), e_data);
    end
  end

  initial begin
    int n;
    int cnt;
    bit got;

    repeat (3) tick();
    chk_en = 1'b1;
    tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_triggered", 32'(triggered), 0);
    check("rst_frame_ready", 32'(frame_ready), 0);
    check("rst_screenData", 32'(screenData), 0);

    // Rising ramp, continuous mode.
    reset = 1'b1; run = 1'b1; trig_level = 12'd1000; trig_slope = 1'b0;
    tick();
    got = 1'b0; n = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      strobe(12'((i * 8) % 4096));
      n = i + 1;
      got = frame_ready;
    end
    check("ramp_ready_after", n, 701);
    run = 1'b0;
    for (int x = 0; x < DEPTH; x++) begin
      screenX = 11'(x);
      tick();
    end
    peek(64, 1000, "ramp_x64");
    peek(63, 992, "ramp_x63");
    peek(0, 488, "ramp_x0");
    peek(639, 1504, "ramp_x639");

    // Falling ramp, single-shot, with idle gaps, a level change after arming and stray arms.
    reset_dut();
    trig_level = 12'd2000; trig_slope = 1'b1; arm = 1'b1;
    tick();
    arm = 1'b0; trig_level = 12'd100;
    got = 1'b0; n = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      arm = (i == 100 || i == 300);
      strobe(12'((4095 - 8 * i) & 4095));
      arm = 1'b0;
      n = i + 1;
      got = frame_ready;
      if (i % 3 == 2) tick();
    end
    check("fall_ready_after", n, 838);
    check("fall_hold_busy", 32'(busy), 0);
    cnt = 0;
    for (int i = 0; i < 700; i++) begin
      strobe(12'(i));
      cnt += int'(frame_ready);
    end
    check("fall_extra_frames", cnt, 0);
    peek(64, 1999, "fall_x64");
    peek(63, 2007, "fall_x63");
    peek(0, 2511, "fall_x0");
    peek(639, 1495, "fall_x639");
    peek(700, 0, "oob_x700");
    screenX = 11'd64;
    check("lat_before_edge0", 32'(screenData), 0);
    tick();
    check("lat_one_cycle0", 32'(screenData), 1999);
    screenX = 11'd700;
    check("lat_before_edge1", 32'(screenData), 1999);
    tick();
    check("lat_one_cycle1", 32'(screenData), 0);

    // Reset while in POST discards the capture.
    reset_dut();
    run = 1'b1; trig_level = 12'd1000; trig_slope = 1'b0;
    tick();
    got = 1'b0; n = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      strobe(12'((i * 8) % 4096));
      n = i + 1;
      got = triggered;
    end
    check("post_trig_after", n, 126);
    for (int i = 126; i < 146; i++) strobe(12'((i * 8) % 4096));
    screenX = 11'd10; run = 1'b0; reset = 1'b0;
    tick();
    check("postrst_busy", 32'(busy), 0);
    check("postrst_screenData", 32'(screenData), 0);
    check("postrst_frame_ready", 32'(frame_ready), 0);
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 700; i++) begin
      strobe(12'((i * 8) % 4096));
      cnt += int'(frame_ready);
    end
    check("postrst_no_frame", cnt, 0);

    // Constant input never crosses the level.
    reset_dut();
    trig_level = 12'd3000; trig_slope = 1'b0; arm = 1'b1;
    tick();
    arm = 1'b0;
    got = 1'b0; n = 0;
    for (int i = 0; i < 4800 && !got; i++) begin
      strobe(12'd100);
      n = i + 1;
      got = frame_ready;
    end
`ifdef TRIG_CAPTURE_AUTO_EN
    check("auto_ready_after", n, 4735);
    peek(0, 100, "auto_x0");
    peek(320, 100, "auto_x320");
    peek(639, 100, "auto_x639");
`else
    check("noauto_no_frame", 32'(got), 0);
    check("noauto_busy", 32'(busy), 1);
    check("noauto_strobes", n, 4800);
`endif

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
